axis_stream_fifo: RTL and testbench

Buffered AXI4-Stream stage that sits directly upstream of the popcount stream slave, between the DMA MM2S stream and the popcount core. It absorbs DMA bursts while the popcount core stalls. It optionally holds data back until a whole packet (TLAST beat) is resident. It exports occupancy and packet statistics for the AXI4-Lite register map.

---
 rtl/axis_stream_fifo_pkg.sv | 15 +
 rtl/axis_stream_fifo_ram.sv | 25 ++
 rtl/axis_stream_fifo.sv | 125 ++++++++++++
 tb/tb_axis_stream_fifo.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_fifo_pkg.sv
// Shared payload layout for the AXI4-Stream FIFO stage.
package axis_stream_fifo_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned ENTRY_W = DATA_W + KEEP_W + 1;

  // One stored beat, packed as {TLAST, TKEEP, TDATA}.
  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_stream_fifo_ram.sv
// DEPTH x ENTRY_W storage: registered write, asynchronous read (distributed RAM).
module axis_stream_fifo_ram
  import axis_stream_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_stream_fifo.sv
// Buffered AXI4-Stream stage with optional store-and-forward and packet statistics.
module axis_stream_fifo
  import axis_stream_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned STORE_FWD = 0,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned LVL_W     = PTR_W + 1
) (
  input  logic             S_AXIS_ACLK,
  input  logic             S_AXIS_ARESETN,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic [3:0]       S_AXIS_TKEEP,
  input  logic             S_AXIS_TLAST,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  output logic [31:0]      M_AXIS_TDATA,
  output logic [3:0]       M_AXIS_TKEEP,
  output logic             M_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  input  logic             FLUSH,
  output logic [LVL_W-1:0] LEVEL,
  output logic [31:0]      PKT_OUT_COUNT
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d, pkts_q, pkts_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic             fallback_q, fallback_d;
  logic             tvalid_q, tvalid_d;
  logic             tready_q, tready_d;
  logic             push, pop;
  logic             push_last, pop_last;
  axis_beat_t       wr_beat, rd_beat;

  // FLUSH blocks both handshakes in the cycle it is high.
  assign S_AXIS_TREADY = tready_q & ~FLUSH;
  assign M_AXIS_TVALID = tvalid_q & ~FLUSH;
  assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
  assign push_last     = push & S_AXIS_TLAST;
  assign pop_last      = pop & rd_beat.last;

  assign wr_beat       = {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};
  assign M_AXIS_TDATA  = tvalid_q ? rd_beat.data : '0;
  assign M_AXIS_TKEEP  = tvalid_q ? rd_beat.keep : '0;
  assign M_AXIS_TLAST  = tvalid_q & rd_beat.last;
  assign LEVEL         = level_q;
  assign PKT_OUT_COUNT = pkt_cnt_q;

  axis_stream_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (S_AXIS_ACLK),
    .wr_en   (push),
    .wr_addr (wptr_q),
    .wr_data (wr_beat),
    .rd_addr (rptr_q),
    .rd_data (rd_beat)
  );

  // Pointer, occupancy, packet tracking and output-valid next state.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    pkts_d     = pkts_q;
    pkt_cnt_d  = pkt_cnt_q;
    fallback_d = 1'b0;
    tvalid_d   = 1'b0;
    tready_d   = 1'b0;

    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      pkts_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
      if (push_last && !pop_last)      pkts_d = pkts_q + LVL_W'(1);
      else if (pop_last && !push_last) pkts_d = pkts_q - LVL_W'(1);
    end

    if (pop_last) pkt_cnt_d = pkt_cnt_q + 32'd1;

    tready_d = (level_d != FULL_LVL);

    if (STORE_FWD != 0) begin
      // Full without a TLAST: stream out until a TLAST is resident or the FIFO empties.
      fallback_d = (level_d != '0) && (pkts_d == '0) &&
                   (fallback_q || (level_d == FULL_LVL));
      tvalid_d   = (level_d != '0) && ((pkts_d != '0) || fallback_d);
    end else begin
      tvalid_d   = (level_d != '0);
    end
  end

  // State registers.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      pkts_q     <= '0;
      pkt_cnt_q  <= '0;
      fallback_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      pkts_q     <= pkts_d;
      pkt_cnt_q  <= pkt_cnt_d;
      fallback_q <= fallback_d;
      tvalid_q   <= tvalid_d;
      tready_q   <= tready_d;
    end
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Bench: cut-through (index 0) and store-and-forward (index 1) instances against a queue model.
module tb_axis_stream_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data  [2];
  logic [3:0]  s_keep  [2];
  logic        s_last  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_keep  [2];
  logic        m_last  [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic        flush   [2];
  logic [4:0]  level_o [2];
  logic [31:0] cnt_o   [2];

  // Reference model state.
  logic [36:0] mq [2][$];
  int          pk     [2];
  bit          fb     [2];
  bit          in_rst [2];
  bit          acc    [2];
  logic [31:0] mcnt   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_stream_fifo #(.DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_data[0]), .S_AXIS_TKEEP(s_keep[0]), .S_AXIS_TLAST(s_last[0]),
    .S_AXIS_TVALID(s_valid[0]), .S_AXIS_TREADY(s_ready[0]),
    .M_AXIS_TDATA(m_data[0]), .M_AXIS_TKEEP(m_keep[0]), .M_AXIS_TLAST(m_last[0]),
    .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TREADY(m_ready[0]),
    .FLUSH(flush[0]), .LEVEL(level_o[0]), .PKT_OUT_COUNT(cnt_o[0])
  );

  axis_stream_fifo #(.DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_data[1]), .S_AXIS_TKEEP(s_keep[1]), .S_AXIS_TLAST(s_last[1]),
    .S_AXIS_TVALID(s_valid[1]), .S_AXIS_TREADY(s_ready[1]),
    .M_AXIS_TDATA(m_data[1]), .M_AXIS_TKEEP(m_keep[1]), .M_AXIS_TLAST(m_last[1]),
    .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TREADY(m_ready[1]),
    .FLUSH(flush[1]), .LEVEL(level_o[1]), .PKT_OUT_COUNT(cnt_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  function automatic bit exp_rdy(input int k);
    return !in_rst[k] && (mq[k].size() != DEPTH) && !flush[k];
  endfunction

  // Cut-through: anything buffered is offered. Store-and-forward: only a
  // complete packet, or the oversize fallback once the FIFO has filled.
  function automatic bit exp_vld(input int k);
    if (in_rst[k] || flush[k] || mq[k].size() == 0) return 1'b0;
    if (k == 0) return 1'b1;
    return (pk[k] > 0) || fb[k];
  endfunction

  task automatic model_clear(input int k);
    mq[k].delete();
    pk[k]     = 0;
    fb[k]     = 1'b0;
    mcnt[k]   = '0;
    in_rst[k] = 1'b1;
  endtask

  task automatic check_outputs(input int k);
    logic [36:0] head;
    chk($sformatf("s_ready%0d", k), 64'(s_ready[k]), 64'(exp_rdy(k)));
    chk($sformatf("m_valid%0d", k), 64'(m_valid[k]), 64'(exp_vld(k)));
    chk($sformatf("level%0d", k), 64'(level_o[k]), 64'(mq[k].size()));
    chk($sformatf("pkt_count%0d", k), 64'(cnt_o[k]), 64'(mcnt[k]));
    if (exp_vld(k)) begin
      head = mq[k][0];
      chk($sformatf("beat%0d", k), 64'({m_last[k], m_keep[k], m_data[k]}), 64'(head));
    end
  endtask

  task automatic model_update(input int k);
    bit          pu, po;
    logic [36:0] b;
    acc[k] = 1'b0;
    if (!rst_n) begin
      model_clear(k);
      return;
    end
    if (in_rst[k]) begin
      in_rst[k] = 1'b0;
      return;
    end
    pu = s_valid[k] && exp_rdy(k);
    po = exp_vld(k) && m_ready[k];
    if (flush[k]) begin
      mq[k].delete();
      pk[k] = 0;
      fb[k] = 1'b0;
      return;
    end
    if (po) begin
      b = mq[k].pop_front();
      if (b[36]) begin
        pk[k]--;
        mcnt[k] = mcnt[k] + 32'd1;
      end
    end
    if (pu) begin
      mq[k].push_back({s_last[k], s_keep[k], s_data[k]});
      if (s_last[k]) pk[k]++;
      acc[k] = 1'b1;
    end
    if (k == 1)
      fb[k] = (mq[k].size() != 0) && (pk[k] == 0) && (fb[k] || mq[k].size() == DEPTH);
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [31:0] d, input logic [3:0] kp, input logic l);
    s_valid[k] = 1'b1;
    s_data[k]  = d;
    s_keep[k]  = kp;
    s_last[k]  = l;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc[k]) break;
    end
    if (!acc[k]) timeout($sformatf("send%0d", k));
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    m_ready[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (mq[k].size() == 0) break;
      tick();
    end
    if (mq[k].size() != 0) timeout($sformatf("drain%0d", k));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_data[k] = '0; s_keep[k] = '0; s_last[k] = 1'b0; s_valid[k] = 1'b0;
      m_ready[k] = 1'b0; flush[k] = 1'b0;
      model_clear(k);
    end

    // Reset state, then release.
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Cut-through 4-beat packet, each beat emerging the cycle after its push.
    m_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) send(0, 32'(i), 4'hF, (i == 4));
    tick();
    tick();
    chk("ct_pkt_count", 64'(cnt_o[0]), 64'd1);
    chk("ct_level_empty", 64'(level_o[0]), 64'd0);

    // Fill to full with downstream stalled; a 17th beat must be refused.
    m_ready[0] = 1'b0;
    for (int i = 1; i <= 16; i++) send(0, 32'(i), 4'($urandom_range(0, 15)), 1'b0);
    chk("full_level", 64'(level_o[0]), 64'd16);
    chk("full_ready", 64'(s_ready[0]), 64'd0);
    s_valid[0] = 1'b1;
    s_data[0]  = 32'd17;
    tick();
    tick();
    chk("full_no_accept", 64'(level_o[0]), 64'd16);
    s_valid[0] = 1'b0;
    drain(0);

    // Store-and-forward: held until TLAST is resident.
    m_ready[1] = 1'b1;
    for (int i = 1; i <= 3; i++) send(1, $urandom, 4'hF, 1'b0);
    tick();
    tick();
    chk("sf_hold", 64'(m_valid[1]), 64'd0);
    send(1, $urandom, 4'h3, 1'b1);
    #1;
    chk("sf_release", 64'(m_valid[1]), 64'd1);
    drain(1);
    tick();
    chk("sf_pkt_count", 64'(cnt_o[1]), 64'd1);

    // Oversize store-and-forward packet: fallback at full avoids deadlock.
    m_ready[1] = 1'b0;
    for (int i = 1; i <= 15; i++) send(1, 32'(i), 4'hF, 1'b0);
    chk("sf_not_full_hold", 64'(m_valid[1]), 64'd0);
    send(1, 32'd16, 4'hF, 1'b0);
    #1;
    chk("sf_fallback", 64'(m_valid[1]), 64'd1);
    m_ready[1] = 1'b1;
    for (int i = 17; i <= 20; i++) send(1, 32'(i), 4'hF, (i == 20));
    drain(1);
    tick();
    chk("sf_big_pkt_count", 64'(cnt_o[1]), 64'd2);

    // Simultaneous push and pop at LEVEL=5.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) send(0, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    m_ready[0] = 1'b1;
    s_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data[0] = 32'(32'h100 + i);
      s_keep[0] = 4'($urandom_range(0, 15));
      tick();
      chk("steady_level", 64'(level_o[0]), 64'd5);
    end
    s_valid[0] = 1'b0;
    drain(0);

    // FLUSH at LEVEL=7 keeps the packet count.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) send(0, $urandom, 4'hF, (i == 3));
    chk("pre_flush_level", 64'(level_o[0]), 64'd7);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    #1;
    chk("flush_level", 64'(level_o[0]), 64'd0);
    chk("flush_valid", 64'(m_valid[0]), 64'd0);
    chk("flush_count", 64'(cnt_o[0]), 64'd1);
    tick();

    // Reset mid-packet clears everything at once; the next packet passes intact.
    for (int i = 0; i < 2; i++) send(0, $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) send(1, $urandom, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) model_clear(k);
    #1;
    chk("rst_valid", 64'(m_valid[0]), 64'd0);
    chk("rst_ready", 64'(s_ready[0]), 64'd0);
    chk("rst_count", 64'(cnt_o[1]), 64'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    m_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) send(0, 32'(32'hA0 + i), 4'hF, (i == 4));
    drain(0);
    tick();
    chk("post_rst_count", 64'(cnt_o[0]), 64'd1);

    // Randomized traffic with occasional flushes on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        s_valid[k] = ($urandom_range(0, 3) != 0);
        s_data[k]  = $urandom;
        s_keep[k]  = 4'($urandom_range(0, 15));
        s_last[k]  = ($urandom_range(0, 5) == 0);
        m_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]   = ($urandom_range(0, 59) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 1'b0;
      flush[k]   = 1'b0;
    end
    tick();
    chk("final_count0", 64'(cnt_o[0]), 64'(mcnt[0]));
    chk("final_count1", 64'(cnt_o[1]), 64'(mcnt[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
